// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-synchronous display update.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero nibble.
module seg7_scan #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [31:0]   pend_data;
  logic          pend;

  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_next;
  logic [7:0]    seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt == LAST);
  assign boundary = slot_end && (idx == 3'd7);
  assign nib      = shadow[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (shadow[4*k +: 4] != 4'h0) msd = 3'(k);
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_next  = (cnt < GUARD) ? '1 : ~(8'h01 << idx);
    seg_next = {~dp_mask[idx], blank ? 7'h7F : hex7(nib)};
  end

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      pend_data  <= '0;
      pend       <= 1'b0;
      an         <= '1;
      seg        <= '1;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx + 3'd1;

      if (load) pend_data <= data;
      // A load on the boundary cycle bypasses pending and commits directly.
      if (boundary) begin
        if (load)      shadow <= data;
        else if (pend) shadow <= pend_data;
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end

      an         <= an_next;
      seg        <= seg_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan using a frame-position reference model.
// Honours SEG7_LEADING_ZERO_BLANK_EN in the model when defined.
module tb_seg7_scan;

  localparam int DC    = 8;
  localparam int GC    = 2;
  localparam int FRAME = 8 * DC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        load;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model state: position within the frame and committed/pending display values.
  int          pos;
  logic [31:0] m_shadow;
  logic [31:0] m_pend;
  bit          m_pflag;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) dut (
    .clk_100MHz(clk),
    .rst       (rst),
    .data      (data),
    .load      (load),
    .dp_mask   (dp_mask),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_an(input int p);
    if ((p % DC) < GC) return 8'hFF;
    return ~(8'h01 << (p / DC));
  endfunction

  function automatic logic [7:0] model_seg(input int p, input logic [7:0] dpm);
    int         digit;
    int         top;
    logic [7:0] lit;
    digit = p / DC;
    lit   = hex_tab[(m_shadow >> (4 * digit)) & 32'hF];
    top   = 0;
    for (int k = 0; k < 8; k++) if (((m_shadow >> (4 * k)) & 32'hF) != 0) top = k;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (digit > top) lit = 8'hFF;
`endif
    return {~dpm[digit], lit[6:0]};
  endfunction

  // Drive one clock cycle and return what the outputs must show after its edge.
  task automatic step(input bit ld, input logic [31:0] d, input logic [7:0] dpm,
                      output logic [7:0] e_an, output logic [7:0] e_seg, output logic e_fd);
    load    = ld;
    data    = d;
    dp_mask = dpm;
    e_an    = model_an(pos);
    e_seg   = model_seg(pos, dpm);
    e_fd    = (pos == FRAME - 1);
    @(posedge clk);
    #1;
    if (pos == FRAME - 1) begin
      if (ld)           m_shadow = d;
      else if (m_pflag) m_shadow = m_pend;
      m_pflag = 0;
    end else if (ld) begin
      m_pend  = d;
      m_pflag = 1;
    end
    pos  = (pos + 1) % FRAME;
    load = 1'b0;
  endtask

  task automatic model_reset();
    pos      = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_pflag  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data = '0; dp_mask = '0;
    #12;
    rst = 1'b0;
    #1;
    total_cnt++; if (an !== 8'hFF)       $display("FAIL reset_an got %h want FF", an);       else pass_cnt++;
    total_cnt++; if (seg !== 8'hFF)      $display("FAIL reset_seg got %h want FF", seg);     else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_scan();
    logic [7:0] ea, es; logic ef;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 32'h0, 8'h00, ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL idle_an cyc %0d got %h want %h", i, an, ea);          else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL idle_seg cyc %0d got %h want %h", i, seg, es);        else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL idle_fd cyc %0d got %b want %b", i, frame_done, ef);  else pass_cnt++;
    end
  endtask

  task automatic test_load_mid_frame();
    logic [7:0] ea, es; logic ef;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(i == 20, 32'h1234ABCD, 8'($urandom), ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL midload_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL midload_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL midload_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  task automatic test_double_load();
    logic [7:0] ea, es; logic ef;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(i == 5 || i == 30, (i == 5) ? 32'h11111111 : 32'h22222222, 8'h00, ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL dbl_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL dbl_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL dbl_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  task automatic test_boundary_load();
    logic [7:0] ea, es; logic ef;
    int n;
    n = (FRAME - 1 - pos + FRAME) % FRAME + FRAME + 1;
    for (int i = 0; i < n; i++) begin
      step(i == n - FRAME - 1, 32'hFFFFFFFF, 8'h00, ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL bnd_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL bnd_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL bnd_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  task automatic test_blank();
    logic [7:0] ea, es; logic ef;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(i == 3, 32'h00000A05, 8'h80, ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL blank_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL blank_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL blank_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] ea, es; logic ef;
    logic [31:0] d;
    for (int i = 0; i < 10 * FRAME; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 15) == 0, d, 8'($urandom), ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL rnd_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL rnd_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL rnd_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [7:0] ea, es; logic ef;
    int n;
    n = (FRAME - pos) % FRAME + 5 * DC + 4;
    for (int i = 0; i < n; i++) begin
      step(i == n - 8, 32'h87654321, 8'h00, ea, es, ef);
      total_cnt++; if (an !== ea)  $display("FAIL rstmid_pre_an cyc %0d got %h want %h", i, an, ea);   else pass_cnt++;
      total_cnt++; if (seg !== es) $display("FAIL rstmid_pre_seg cyc %0d got %h want %h", i, seg, es); else pass_cnt++;
    end
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (an !== 8'hFF)  $display("FAIL rstmid_an got %h want FF", an);   else pass_cnt++;
    total_cnt++; if (seg !== 8'hFF) $display("FAIL rstmid_seg got %h want FF", seg); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (an !== 8'hFF)  $display("FAIL rstheld_an got %h want FF", an);   else pass_cnt++;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 32'h0, 8'h00, ea, es, ef);
      total_cnt++; if (an !== ea)         $display("FAIL rstmid_an cyc %0d got %h want %h", i, an, ea);         else pass_cnt++;
      total_cnt++; if (seg !== es)        $display("FAIL rstmid_seg cyc %0d got %h want %h", i, seg, es);       else pass_cnt++;
      total_cnt++; if (frame_done !== ef) $display("FAIL rstmid_fd cyc %0d got %b want %b", i, frame_done, ef); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_mid_frame();
    test_double_load();
    test_boundary_load();
    test_blank();
    test_random();
    test_reset_mid_slot();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
